// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the MIPS-subset multiply/divide unit:
//                operation select codes, multicycle FSM state encodings and
//                the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Default operand width; the iteration count equals the width.
    localparam int WIDTH_DEFAULT = 32;

    // Operation select driven by the control FSM.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Multiply/divide FSM state encodings.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MULT   = 2'd1;
    localparam logic [1:0] ST_DIV    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mult_div_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration on unsigned
//                magnitudes. Shifts the next dividend bit into the partial
//                remainder and subtracts the divisor when it fits.
//  Ports       : i_rem      - partial remainder (always < divisor)
//                i_dvd_bit  - next dividend bit, MSB first
//                i_divisor  - divisor magnitude
//                o_rem      - next partial remainder
//                o_q_bit    - quotient bit produced by this iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    // One extra bit so the shifted remainder never truncates.
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_shifted = {i_rem, i_dvd_bit};
        w_trial   = w_shifted - {1'b0, i_divisor};
        o_q_bit   = (w_shifted >= {1'b0, i_divisor});
        // The result is below the divisor, so WIDTH bits always suffice.
        o_rem     = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multicycle signed multiply (radix-2 Booth) and signed
//                restoring divide, one step per clock, WIDTH steps per op.
//                Results are held in the HI/LO registers.
//  Ports       : clk      - clock
//                reset    - synchronous active-high reset (aborts an op)
//                start    - request pulse, sampled only while idle
//                op       - 0 = signed mult, 1 = signed div
//                a, b     - operands (multiplicand/dividend, multiplier/divisor)
//                hi, lo   - product halves, or remainder / quotient
//                busy     - operation in progress
//                done     - one-cycle completion pulse
//                div_zero - last accepted div had a zero divisor
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    //   acc_q : Booth accumulator (WIDTH+1 bits) during mult; its low
    //           WIDTH bits hold the partial remainder during div.
    //   q_q   : multiplier during mult; dividend shifting out MSB-first
    //           with quotient bits shifting in at the LSB during div.
    //   m_q   : multiplicand during mult; divisor magnitude during div.
    // ------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             op_q,       op_d;
    logic [WIDTH:0]   acc_q,      acc_d;
    logic [WIDTH-1:0] q_q,        q_d;
    logic             qm1_q,      qm1_d;
    logic [WIDTH-1:0] m_q,        m_d;
    logic             sign_a_q,   sign_a_d;
    logic             sign_b_q,   sign_b_d;
    logic             dz_pend_q,  dz_pend_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;

    // Magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) read as unsigned.
    assign w_abs_a = a[WIDTH-1] ? -a : a;
    assign w_abs_b = b[WIDTH-1] ? -b : b;

    // Booth add/subtract of the sign-extended multiplicand.
    assign w_m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        w_booth_sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   w_booth_sum = acc_q + w_m_ext;
            2'b10:   w_booth_sum = acc_q - w_m_ext;
            default: w_booth_sum = acc_q;
        endcase
    end

    div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .i_rem     (acc_q[WIDTH-1:0]),
        .i_dvd_bit (q_q[WIDTH-1]),
        .i_divisor (m_q),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        acc_d      = acc_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        dz_pend_d  = dz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d       = op;
                    busy_d     = 1'b1;
                    div_zero_d = 1'b0;
                    count_d    = '0;
                    acc_d      = '0;
                    qm1_d      = 1'b0;
                    sign_a_d   = a[WIDTH-1];
                    sign_b_d   = b[WIDTH-1];
                    dz_pend_d  = 1'b0;
                    if (op == OP_MULT) begin
                        m_d     = a;
                        q_d     = b;
                        state_d = ST_MULT;
                    end else begin
                        m_d = w_abs_b;
                        q_d = w_abs_a;
                        if (b == '0) begin
                            // Skip the iterations; FINISH flags the error.
                            dz_pend_d = 1'b1;
                            state_d   = ST_FINISH;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end
                end
            end

            ST_MULT: begin
                // Arithmetic shift right of {acc, Q, q_-1}.
                acc_d   = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
                q_d     = {w_booth_sum[0], q_q[WIDTH-1:1]};
                qm1_d   = q_q[0];
                count_d = count_q + CNT_W'(1);
                if (count_q == C_LAST_STEP) begin
                    state_d = ST_FINISH;
                end
            end

            ST_DIV: begin
                acc_d   = {1'b0, w_rem_next};
                q_d     = {q_q[WIDTH-2:0], w_q_bit};
                count_d = count_q + CNT_W'(1);
                if (count_q == C_LAST_STEP) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (op_q == OP_MULT) begin
                    // Low 2*WIDTH bits of the sign-extended product.
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = q_q;
                end else if (dz_pend_q) begin
                    div_zero_d = 1'b1;
                end else begin
                    lo_d = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
                    // Remainder takes the sign of the dividend.
                    hi_d = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            op_q       <= OP_MULT;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            dz_pend_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            dz_pend_q  <= dz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Expected HI/LO/
//                div_zero values are queued when a request is issued and
//                compared by a monitor when done pulses; each scenario task
//                also checks latency, busy and flag behaviour inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          div_zero;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           passes = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         prev_done = 1'b0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Reference arithmetic on 64-bit signed values; a zero divisor keeps
    // the previous HI/LO.
    function automatic logic [63:0] ref_result(input logic o, input logic [W-1:0] x,
                                               input logic [W-1:0] y, input logic [63:0] prev);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p = sx * sy;
            return p;
        end
        if (y == '0) return prev;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Scoreboard monitor: compares results whenever done pulses.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && done) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_done: done with no pending request");
            end else begin
                e = sb.pop_front();
                if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
                    $display("FAIL sb_result: hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                             hi, lo, div_zero, e.hi, e.lo, e.dz);
                else
                    passes++;
            end
            checks++;
            if (prev_done)
                $display("FAIL done_pulse_width: done high for two consecutive cycles");
            else
                passes++;
        end
        prev_done = done;
    end

    // Drive a request (current time is just after a rising edge); returns
    // just after the accept edge with operands scrambled to prove latching.
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = edz;
        sb.push_back(e);
        m_hi = eh;
        m_lo = el;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = $urandom_range(0, 1);
    endtask

    task automatic issue_model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] r;
        r = ref_result(o, x, y, {m_hi, m_lo});
        issue(o, x, y, r[63:32], r[31:0], o && (y == '0));
    endtask

    // Wait (bounded) for done; lat counts edges after the accept edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        if (!done) begin
            checks++;
            $display("FAIL wait_done_timeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (hi !== '0) $display("FAIL reset_hi: got %h want 0", hi); else passes++;
        checks++; if (lo !== '0) $display("FAIL reset_lo: got %h want 0", lo); else passes++;
        checks++; if ({busy, done, div_zero} !== 3'b000)
            $display("FAIL reset_flags: busy/done/dz=%b want 000", {busy, done, div_zero});
        else passes++;
    endtask

    task automatic test_mult;
        int lat, bc;
        issue(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat != LAT) $display("FAIL mult_latency: got %0d want %0d", lat, LAT); else passes++;
        checks++; if (bc != LAT) $display("FAIL mult_busy_cycles: got %0d want %0d", bc, LAT); else passes++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) $display("FAIL mult_done_clear: got %b want 0", done); else passes++;
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        wait_done(lat, bc);
        issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(lat, bc);
        for (int i = 0; i < 6; i++) begin
            issue_model(1'b0, $urandom, $urandom);
            wait_done(lat, bc);
        end
    endtask

    task automatic test_div;
        int lat, bc;
        logic [W-1:0] y;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat != LAT) $display("FAIL div_latency: got %0d want %0d", lat, LAT); else passes++;
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        wait_done(lat, bc);
        for (int i = 0; i < 6; i++) begin
            y = (i % 2 == 0) ? W'($signed($urandom_range(0, 40)) - 20) : $urandom;
            if (y == '0) y = 32'd3;
            issue_model(1'b1, $urandom, y);
            wait_done(lat, bc);
        end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        issue(1'b0, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 1'b0);
        wait_done(lat, bc);
        issue(1'b1, 32'd5, 32'd0, 32'h0000_0000, 32'h0001_2340, 1'b1);
        wait_done(lat, bc);
        checks++; if (lat != 1) $display("FAIL dz_latency: got %0d want 1", lat); else passes++;
        checks++; if (bc != 1) $display("FAIL dz_busy_cycles: got %0d want 1", bc); else passes++;
        checks++; if ({hi, lo} !== {32'h0000_0000, 32'h0001_2340})
            $display("FAIL dz_hilo_kept: got %h_%h want 00000000_00012340", hi, lo);
        else passes++;
        repeat (3) @(posedge clk); #1;
        checks++; if (div_zero !== 1'b1) $display("FAIL dz_sticky: got %b want 1", div_zero); else passes++;
        issue(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        checks++; if (div_zero !== 1'b0) $display("FAIL dz_clear_on_start: got %b want 0", div_zero); else passes++;
        wait_done(lat, bc);
    endtask

    task automatic test_overflow;
        int lat, bc;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat != LAT) $display("FAIL ovf_latency: got %0d want %0d", lat, LAT); else passes++;
    endtask

    task automatic test_busy_ignore_and_reset;
        int lat, bc;
        issue(1'b0, 32'hFFFF_FF00, 32'd1000, 32'hFFFF_FFFF, 32'hFFFC_1800, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        op = 1'b1; a = 32'd99; b = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL ignore_busy: got %b want 1", busy); else passes++;
        wait_done(lat, bc);
        checks++; if (lat != LAT - 6) $display("FAIL ignore_latency: got %0d want %0d", lat, LAT - 6);
        else passes++;

        // Second op aborted by reset at iteration 10.
        issue(1'b1, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0;
        checks++; if ({hi, lo, busy, done, div_zero} !== '0)
            $display("FAIL abort_outputs: hi=%h lo=%h busy/done/dz=%b want all 0",
                     hi, lo, {busy, done, div_zero});
        else passes++;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        checks++; if (lat != 0) $display("FAIL abort_no_done: got %0d done pulses want 0", lat); else passes++;
        issue_model(1'b1, 32'hFFFF_FC18, 32'd7);
        wait_done(lat, bc);
        checks++; if (lat != LAT) $display("FAIL fresh_latency: got %0d want %0d", lat, LAT); else passes++;
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue_model(1'b1, 32'd100, 32'd9);
        wait_done(lat, bc);
        // Issued while done is high: accepted on the next edge.
        issue_model(1'b0, 32'hFFFF_FFF0, 32'd5);
        checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b want 1", busy); else passes++;
        wait_done(lat, bc);
        checks++; if (lat != LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); else passes++;
        issue_model(1'b1, 32'd42, 32'd0);
        wait_done(lat, bc);
        issue_model(1'b1, 32'd42, 32'd5);
        wait_done(lat, bc);
        checks++; if (div_zero !== 1'b0) $display("FAIL b2b_dz_clear: got %b want 0", div_zero); else passes++;
    endtask

    initial begin
        start = 1'b0; op = 1'b0; a = '0; b = '0; reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_overflow();
        test_busy_ignore_and_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sb.size() != 0) $display("FAIL sb_drain: %0d results never produced", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
